// File: rtl/ysyx_25020042_exec_sequencer.sv
// Multi-cycle control FSM for the NPC integer datapath: fetch, decode, execute, write-back.
// Instructions that the decoder reports as unsupported stop the sequencer in HALT until reset.
module ysyx_25020042_exec_sequencer #(
  parameter int unsigned              INS_BYTES = 4,
  parameter logic [INS_BYTES*8-1:0]   RESET_PC  = 32'h8000_0000,
  parameter int unsigned              PC_STEP   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     imem_req_valid,
  output logic [INS_BYTES*8-1:0]   imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [INS_BYTES*8-1:0]   imem_rsp_data,
  output logic [INS_BYTES*8-1:0]   ins,
  input  logic [7:0]               dec_instruction,
  output logic                     alu_en,
  output logic                     rf_wen,
  output logic [INS_BYTES*8-1:0]   pc,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal,
  output logic [INS_BYTES*8-1:0]   instret
);

  localparam int unsigned XLEN = INS_BYTES * 8;
  localparam logic [XLEN-1:0] PcStep = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] One    = XLEN'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFetchReq,
    StFetchWait,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ins_q;
  logic [XLEN-1:0] instret_q;
  logic            illegal_q;
  logic            req_valid_q;
  logic            alu_en_q;
  logic            rf_wen_q;
  logic            busy_q;
  logic            halted_q;

  // Every output flag is updated on the same edge as the state transition that implies it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      ins_q       <= '0;
      instret_q   <= '0;
      illegal_q   <= 1'b0;
      req_valid_q <= 1'b0;
      alu_en_q    <= 1'b0;
      rf_wen_q    <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      alu_en_q <= 1'b0;
      rf_wen_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StFetchReq;
            req_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StFetchReq: begin
          if (imem_req_ready) begin
            state_q     <= StFetchWait;
            req_valid_q <= 1'b0;
          end
        end
        StFetchWait: begin
          if (imem_rsp_valid) begin
            ins_q   <= imem_rsp_data;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (dec_instruction == 8'h00) begin
            state_q   <= StHalt;
            illegal_q <= 1'b1;
            busy_q    <= 1'b0;
            halted_q  <= 1'b1;
          end else begin
            state_q  <= StExec;
            alu_en_q <= 1'b1;
          end
        end
        StExec: begin
          state_q  <= StWb;
          rf_wen_q <= 1'b1;
        end
        StWb: begin
          pc_q        <= pc_q + PcStep;
          instret_q   <= instret_q + One;
          state_q     <= StFetchReq;
          req_valid_q <= 1'b1;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q     <= StIdle;
          req_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign ins            = ins_q;
  assign alu_en         = alu_en_q;
  assign rf_wen         = rf_wen_q;
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_ysyx_25020042_exec_sequencer.sv
// Directed bench for the exec sequencer; a second instance with RESET_PC near the top of the
// address space shares the stimulus so PC wrap-around can be observed.
module tb_ysyx_25020042_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        req_valid1, alu_en1, rf_wen1, busy1, halted1, illegal1;
  logic [31:0] req_addr1, ins1, pc1, instret1;
  logic [7:0]  dec1;
  logic        req_valid2, alu_en2, rf_wen2, busy2, halted2, illegal2;
  logic [31:0] req_addr2, ins2, pc2, instret2;
  logic [7:0]  dec2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Tiny decoder stand-in: only OP-IMM (opcode 0x13) is supported.
  assign dec1 = (ins1[6:0] == 7'h13) ? 8'h13 : 8'h00;
  assign dec2 = (ins2[6:0] == 7'h13) ? 8'h13 : 8'h00;

  ysyx_25020042_exec_sequencer #(
    .INS_BYTES (4),
    .RESET_PC  (32'h8000_0000),
    .PC_STEP   (4)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .imem_req_valid  (req_valid1),
    .imem_req_addr   (req_addr1),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .ins             (ins1),
    .dec_instruction (dec1),
    .alu_en          (alu_en1),
    .rf_wen          (rf_wen1),
    .pc              (pc1),
    .busy            (busy1),
    .halted          (halted1),
    .illegal         (illegal1),
    .instret         (instret1)
  );

  ysyx_25020042_exec_sequencer #(
    .INS_BYTES (4),
    .RESET_PC  (32'hFFFF_FFFC),
    .PC_STEP   (4)
  ) u_dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .imem_req_valid  (req_valid2),
    .imem_req_addr   (req_addr2),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .ins             (ins2),
    .dec_instruction (dec2),
    .alu_en          (alu_en2),
    .rf_wen          (rf_wen2),
    .pc              (pc2),
    .busy            (busy2),
    .halted          (halted2),
    .illegal         (illegal2),
    .instret         (instret2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in FETCH_REQ; leaves the DUT in the next FETCH_REQ.
  task automatic run_instr(input int rdly, input int sdly, input logic [31:0] word);
    imem_req_ready = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      chk("ri_req_valid_hold", {31'd0, req_valid1}, 32'd1);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < sdly; i++) begin
      chk("ri_wait_no_req", {31'd0, req_valid1}, 32'd0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    tick();
    imem_rsp_valid = 1'b0;
    chk("ri_decode_quiet", {30'd0, alu_en1, rf_wen1}, 32'd0);
    tick();
    chk("ri_exec_strobes", {30'd0, alu_en1, rf_wen1}, 32'd2);
    tick();
    chk("ri_wb_strobes", {30'd0, alu_en1, rf_wen1}, 32'd1);
    tick();
    chk("ri_next_req", {31'd0, req_valid1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_pc", pc1, 32'h8000_0000);
    chk("rst_ins", ins1, 32'h0);
    chk("rst_instret", instret1, 32'h0);
    chk("rst_flags", {26'd0, req_valid1, alu_en1, rf_wen1, busy1, halted1, illegal1}, 32'd0);

    // 1. Best-case single instruction
    rst_n = 1'b1;
    start = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_req_valid", {31'd0, req_valid1}, 32'd1);
    chk("t1_req_addr", req_addr1, 32'h8000_0000);
    chk("t1_busy", {31'd0, busy1}, 32'd1);
    tick();                               // handshake edge
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    chk("t1_wait_req_low", {31'd0, req_valid1}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    chk("t1_ins", ins1, 32'h0050_0093);
    chk("t1_decode_alu", {31'd0, alu_en1}, 32'd0);
    tick();
    chk("t1_exec", {30'd0, alu_en1, rf_wen1}, 32'd2);
    tick();
    chk("t1_wb", {30'd0, alu_en1, rf_wen1}, 32'd1);
    chk("t1_wb_pc_old", pc1, 32'h8000_0000);
    tick();
    chk("t1_pc", pc1, 32'h8000_0004);
    chk("t1_instret", instret1, 32'd1);
    chk("t1_next_req", {31'd0, req_valid1}, 32'd1);
    chk("t1_next_addr", req_addr1, 32'h8000_0004);

    // 2. Back-pressure with a stray response
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = (i == 1);
      imem_rsp_data  = 32'hDEAD_BEEF;
      chk("t2_hold_valid", {31'd0, req_valid1}, 32'd1);
      chk("t2_hold_addr", req_addr1, 32'h8000_0004);
      tick();
    end
    imem_rsp_valid = 1'b0;
    chk("t2_valid_5th", {31'd0, req_valid1}, 32'd1);
    chk("t2_addr_5th", req_addr1, 32'h8000_0004);
    chk("t2_stray_ignored", ins1, 32'h0050_0093);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t2_wait", {30'd0, req_valid1, busy1}, 32'd1);

    // 3. Unsupported instruction halts
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0033;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t3_ins", ins1, 32'h0000_0033);
    tick();
    chk("t3_halt_flags", {26'd0, req_valid1, alu_en1, rf_wen1, busy1, halted1, illegal1},
        32'h03);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("t3_still_halt", {26'd0, req_valid1, alu_en1, rf_wen1, busy1, halted1, illegal1},
        32'h03);
    chk("t3_pc_frozen", pc1, 32'h8000_0004);
    chk("t3_instret_frozen", instret1, 32'd1);

    // 4. Reset during FETCH_WAIT, late response ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_clear", {30'd0, halted1, illegal1}, 32'd0);
    start = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    chk("t4_in_wait", {30'd0, req_valid1, busy1}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    tick();
    imem_rsp_valid = 1'b0;
    chk("t4_late_ins", ins1, 32'h0);
    chk("t4_pc", pc1, 32'h8000_0000);
    chk("t4_instret", instret1, 32'd0);
    chk("t4_idle", {29'd0, req_valid1, busy1, alu_en1}, 32'd0);

    // 5. PC wrap on the high-reset instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_pc", pc2, 32'hFFFF_FFFC);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_req_addr", req_addr2, 32'hFFFF_FFFC);
    run_instr(0, 0, 32'h0050_0093);
    chk("t5_pc_wrap", pc2, 32'h0000_0000);
    chk("t5_addr_wrap", req_addr2, 32'h0000_0000);
    chk("t5_instret", instret2, 32'd1);

    // 6. Three instructions with random handshake delays
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 32'h0010_8093);
    end
    chk("t6_instret", instret1, 32'd3);
    chk("t6_pc", pc1, 32'h8000_000C);
    chk("t6_pc_wrapinst", pc2, 32'h0000_0008);
    chk("t6_not_illegal", {31'd0, illegal1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
